// File: rtl/spi_xfer_sequencer_pkg.sv
// Shared FSM encoding, SPI mode constants and the enable rule for the
// SPI burst sequencer.
package spi_xfer_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_ARM      = 3'd2,
    ST_WAIT_TIP = 3'd3,
    ST_XFER     = 3'd4,
    ST_GAP      = 3'd5,
    ST_DONE     = 3'd6,
    ST_ABORT    = 3'd7
  } state_t;

  localparam logic [1:0] SPI_MODE_RUN  = 2'b00;
  localparam logic [1:0] SPI_MODE_WAIT = 2'b01;

  function automatic logic spi_enabled(input logic       mstr,
                                       input logic       spiswai,
                                       input logic [1:0] mode);
    return mstr && !spiswai && (mode == SPI_MODE_RUN || mode == SPI_MODE_WAIT);
  endfunction

endpackage

// File: rtl/spi_xfer_sequencer.sv
// Multi-byte SPI master burst sequencer: pops TX bytes, pulses send_data per
// byte, captures RX bytes, spaces bytes by a gap and reports done/abort.
module spi_xfer_sequencer
  import spi_xfer_sequencer_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int LEN_W       = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int TIP_TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              mstr,
  input  logic              spiswai,
  input  logic [1:0]        spi_mode,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              send_data,
  output logic [DATA_W-1:0] data_mosi,
  input  logic              tip,
  input  logic              receive_data,
  input  logic [DATA_W-1:0] miso_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              abort_err
);

  localparam int TO_W  = $clog2(TIP_TIMEOUT);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIP_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nx;
  logic [LEN_W-1:0]    r_rem;
  logic [GAP_W-1:0]    r_gap;
  logic [TO_W-1:0]     r_to;
  logic [DATA_W-1:0]   r_mosi;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_rx_valid;
  logic                r_zero_done;

  logic w_en;
  logic w_start_ok;
  logic w_pop;
  logic w_rx_cap;

  assign w_en       = spi_enabled(mstr, spiswai, spi_mode);
  assign w_start_ok = (r_state == ST_IDLE) && start && w_en;
  assign w_pop      = (r_state == ST_LOAD) && w_en && tx_valid;
  assign w_rx_cap   = (r_state == ST_XFER) && receive_data;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= ST_IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:     if (w_start_ok && burst_len != '0) w_state_nx = ST_LOAD;
      ST_LOAD:     if (tx_valid) w_state_nx = ST_ARM;
      ST_ARM:      w_state_nx = ST_WAIT_TIP;
      ST_WAIT_TIP: begin
        if (tip)                  w_state_nx = ST_XFER;
        else if (r_to == TO_LAST) w_state_nx = ST_ABORT;
      end
      ST_XFER:     if (receive_data)
                     w_state_nx = (r_rem == LEN_W'(1)) ? ST_DONE : ST_GAP;
      ST_GAP:      if (!tip && r_gap == GAP_LAST) w_state_nx = ST_LOAD;
      ST_DONE:     w_state_nx = ST_IDLE;
      ST_ABORT:    w_state_nx = ST_IDLE;
      default:     w_state_nx = ST_IDLE;
    endcase
    // Losing enable mid-burst overrides every other transition.
    if (r_state != ST_IDLE && r_state != ST_ABORT && !w_en) w_state_nx = ST_ABORT;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rem       <= '0;
      r_gap       <= '0;
      r_to        <= '0;
      r_mosi      <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_zero_done <= 1'b0;
    end else begin
      r_rx_valid  <= w_rx_cap;
      r_zero_done <= w_start_ok && (burst_len == '0);
      if (w_rx_cap) r_rx_data <= miso_data;
      if (w_pop)    r_mosi    <= tx_data;
      case (r_state)
        ST_IDLE:     if (w_start_ok) r_rem <= burst_len;
        // The ARM cycle is the first cycle of the tip timeout window.
        ST_ARM:      r_to <= TO_W'(1);
        ST_WAIT_TIP: r_to <= r_to + TO_W'(1);
        ST_XFER: begin
          r_gap <= '0;
          if (receive_data && w_en && r_rem != LEN_W'(1)) r_rem <= r_rem - LEN_W'(1);
        end
        ST_GAP:      r_gap <= tip ? '0 : r_gap + GAP_W'(1);
        ST_ABORT:    r_rem <= '0;
        default:     ;
      endcase
    end
  end

  assign tx_ready  = (r_state == ST_LOAD) && w_en;
  assign send_data = (r_state == ST_ARM) && w_en;
  assign data_mosi = r_mosi;
  assign rx_valid  = r_rx_valid;
  assign rx_data   = r_rx_data;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE) || r_zero_done;
  assign abort_err = (r_state == ST_ABORT);

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer: TX source, loopback slave model and a
// scoreboard checking every send/receive/done/abort event.
module tb_spi_xfer_sequencer;
  localparam int DATA_W = 8, LEN_W = 8, GAP_CYCLES = 2, TIP_TIMEOUT = 16;

  logic             PCLK = 1'b0, PRESETn = 1'b0;
  logic             mstr = 1'b1, spiswai = 1'b0;
  logic [1:0]       spi_mode = 2'b00;
  logic             start = 1'b0;
  logic [LEN_W-1:0] burst_len = '0;
  logic             tx_valid = 1'b0;
  logic [7:0]       tx_data = '0;
  logic             tx_ready, send_data;
  logic [7:0]       data_mosi;
  logic             tip = 1'b0, receive_data = 1'b0;
  logic [7:0]       miso_data = '0;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             busy, done, abort_err;

  spi_xfer_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W), .GAP_CYCLES(GAP_CYCLES),
                       .TIP_TIMEOUT(TIP_TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .mstr(mstr), .spiswai(spiswai), .spi_mode(spi_mode),
    .start(start), .burst_len(burst_len), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .send_data(send_data), .data_mosi(data_mosi), .tip(tip),
    .receive_data(receive_data), .miso_data(miso_data), .rx_valid(rx_valid),
    .rx_data(rx_data), .busy(busy), .done(done), .abort_err(abort_err));

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected burst contents and event bookkeeping
  logic [7:0] m_tx[$];
  logic [7:0] tx_q[$];
  logic [7:0] rx_log[$];
  int si = 0, ri = 0, exp_len = 0;
  int n_send = 0, n_rx = 0, n_done = 0, n_abort = 0, n_busy = 0, n_txr = 0;
  int first_send_cyc = -1, send_cyc = -1, rx_cyc = -1, done_cyc = -1, abort_cyc = -1;
  logic slave_en = 1'b1;

  // TX source: present the queue head, pop on a sampled valid&ready.
  logic pend = 1'b0;
  always begin
    @(negedge PCLK); #1;
    if (!PRESETn) pend = 1'b0;
    else if (pend && tx_q.size() > 0) void'(tx_q.pop_front());
    tx_valid = (tx_q.size() > 0);
    tx_data  = tx_valid ? tx_q[0] : 8'h00;
    pend     = tx_ready & tx_valid;
  end

  // Loopback slave: tip for three cycles after send_data, byte returned inverted.
  int scnt = 0;
  always begin
    @(negedge PCLK); #1;
    if (!PRESETn) begin
      tip = 1'b0; receive_data = 1'b0; scnt = 0;
    end else if (scnt == 0) begin
      receive_data = 1'b0;
      if (send_data && slave_en) begin tip = 1'b1; scnt = 1; end
    end else begin
      scnt++;
      if (scnt == 3) begin receive_data = 1'b1; miso_data = ~data_mosi; end
      else if (scnt == 4) begin receive_data = 1'b0; tip = 1'b0; scnt = 0; end
    end
  end

  // Scoreboard compare process
  always begin
    logic [7:0] e;
    @(negedge PCLK); #2;
    if (PRESETn) begin
      if (busy) n_busy++;
      if (tx_ready) n_txr++;
      if (!busy) begin
        check("idle_tx_ready", tx_ready, 1'b0);
        check("idle_send_data", send_data, 1'b0);
      end
      if (send_data) begin
        if (si < m_tx.size()) check("mosi", data_mosi, m_tx[si]);
        else check("send_count", si + 1, m_tx.size());
        if (si == 0) first_send_cyc = cyc;
        si++; n_send++; send_cyc = cyc;
      end
      if (rx_valid) begin
        if (ri < m_tx.size()) begin
          e = ~m_tx[ri];
          check("rx_data", rx_data, e);
        end else check("rx_count", ri + 1, m_tx.size());
        rx_log.push_back(rx_data);
        ri++; n_rx++; rx_cyc = cyc;
      end
      if (done) begin
        check("done_after_all_rx", ri, exp_len);
        n_done++; done_cyc = cyc;
      end
      if (abort_err) begin
        check("abort_not_with_done", done, 1'b0);
        n_abort++; abort_cyc = cyc;
      end
    end
  end

  int start_cyc = 0;
  task automatic do_start(input logic [7:0] len);
    @(negedge PCLK);
    burst_len = len; start = 1'b1; start_cyc = cyc;
    @(negedge PCLK);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge PCLK); #3;
      if (!busy) break;
    end
    check("idle_reached", busy, 1'b0);
    repeat (2) @(negedge PCLK);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_tx_ready"}, tx_ready, 1'b0);
    check({tag, "_send_data"}, send_data, 1'b0);
    check({tag, "_rx_valid"}, rx_valid, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_abort"}, abort_err, 1'b0);
    check({tag, "_mosi"}, data_mosi, 8'h00);
    check({tag, "_rx_data"}, rx_data, 8'h00);
  endtask

  task automatic new_burst(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input int n);
    logic [7:0] bl[4];
    bl = '{b0, b1, b2, b3};
    m_tx.delete(); si = 0; ri = 0; exp_len = n;
    for (int i = 0; i < n; i++) begin m_tx.push_back(bl[i]); tx_q.push_back(bl[i]); end
  endtask

  int b_send, b_rx, b_done, b_abort, b_busy, b_txr, sw_cyc, k;

  initial begin
    // Reset state
    repeat (3) @(negedge PCLK);
    #3 check_zero("reset");
    @(negedge PCLK); PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);

    // Burst of 3 with loopback
    new_burst(8'hA5, 8'h3C, 8'hFF, 8'h00, 3);
    b_send = n_send; b_rx = n_rx; b_done = n_done; b_abort = n_abort;
    do_start(8'd3);
    wait_idle();
    check("b3_first_send_latency", first_send_cyc - start_cyc, 2);
    check("b3_sends", n_send - b_send, 3);
    check("b3_rx", n_rx - b_rx, 3);
    check("b3_done", n_done - b_done, 1);
    check("b3_abort", n_abort - b_abort, 0);
    check("b3_done_with_last_rx", done_cyc, rx_cyc);
    check("b3_rx0", rx_log[rx_log.size()-3], 8'h5A);
    check("b3_rx1", rx_log[rx_log.size()-2], 8'hC3);
    check("b3_rx2", rx_log[rx_log.size()-1], 8'h00);

    // Zero-length burst
    new_burst(8'h00, 8'h00, 8'h00, 8'h00, 0);
    b_send = n_send; b_done = n_done; b_busy = n_busy; b_txr = n_txr;
    do_start(8'd0);
    repeat (3) @(negedge PCLK);
    check("zero_done", n_done - b_done, 1);
    check("zero_done_latency", done_cyc - start_cyc, 1);
    check("zero_no_send", n_send - b_send, 0);
    check("zero_no_tx_ready", n_txr - b_txr, 0);
    check("zero_no_busy", n_busy - b_busy, 0);

    // TX stall in LOAD
    new_burst(8'h96, 8'h00, 8'h00, 8'h00, 1);
    tx_q.delete();
    b_send = n_send; b_done = n_done;
    do_start(8'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK); #3;
      check("stall_send", send_data, 1'b0);
      check("stall_busy", busy, 1'b1);
      check("stall_tx_ready", tx_ready, 1'b1);
    end
    tx_q.push_back(8'h96);
    wait_idle();
    check("stall_sends", n_send - b_send, 1);
    check("stall_done", n_done - b_done, 1);
    check("stall_rx", rx_log[rx_log.size()-1], 8'h69);

    // tip never rises
    slave_en = 1'b0;
    new_burst(8'h11, 8'h00, 8'h00, 8'h00, 1);
    b_done = n_done; b_abort = n_abort; b_rx = n_rx;
    do_start(8'd1);
    wait_idle();
    check("to_abort", n_abort - b_abort, 1);
    check("to_latency", abort_cyc - send_cyc, TIP_TIMEOUT);
    check("to_no_done", n_done - b_done, 0);
    check("to_no_rx", n_rx - b_rx, 0);
    check("to_busy", busy, 1'b0);
    slave_en = 1'b1;

    // spiswai during XFER of byte 2 of 4 (same cycle as its capture)
    new_burst(8'h01, 8'h02, 8'h03, 8'h04, 4);
    b_send = n_send; b_rx = n_rx; b_done = n_done; b_abort = n_abort;
    do_start(8'd4);
    for (k = 0; k < 200; k++) begin
      @(negedge PCLK); #3;
      if (n_send - b_send >= 2) break;
    end
    check("sw_second_send_seen", n_send - b_send, 2);
    @(negedge PCLK);
    @(negedge PCLK);
    spiswai = 1'b1; sw_cyc = cyc;
    wait_idle();
    spiswai = 1'b0;
    tx_q.delete();
    check("sw_abort", n_abort - b_abort, 1);
    check("sw_abort_latency", abort_cyc - sw_cyc, 1);
    check("sw_sends", n_send - b_send, 2);
    check("sw_no_done", n_done - b_done, 0);
    check("sw_rx_kept", n_rx - b_rx, 2);

    // Reset asserted in GAP, then a full burst
    new_burst(8'hC0, 8'hC1, 8'hC2, 8'h00, 3);
    b_done = n_done; b_abort = n_abort; b_rx = n_rx;
    do_start(8'd3);
    for (k = 0; k < 200; k++) begin
      @(negedge PCLK); #3;
      if (n_rx - b_rx >= 1) break;
    end
    check("rst_first_rx_seen", n_rx - b_rx, 1);
    #1 PRESETn = 1'b0;
    #1 check_zero("rst_gap");
    tx_q.delete();
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);
    check("rst_no_done", n_done - b_done, 0);
    check("rst_no_abort", n_abort - b_abort, 0);
    new_burst(8'hE7, 8'h18, 8'h00, 8'h00, 2);
    b_send = n_send; b_rx = n_rx; b_done = n_done;
    do_start(8'd2);
    wait_idle();
    check("post_sends", n_send - b_send, 2);
    check("post_rx", n_rx - b_rx, 2);
    check("post_done", n_done - b_done, 1);
    check("post_rx0", rx_log[rx_log.size()-2], 8'h18);
    check("post_rx1", rx_log[rx_log.size()-1], 8'hE7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
